// File: rtl/exe_pkg.sv
// exe_pkg: shared widths, request payload struct and branch-mask helpers for the exe request stage.
package exe_pkg;
    localparam int BR_W   = 20;
    localparam int DATA_W = 65;
    localparam int ROB_W  = 7;
    localparam int PREG_W = 7;

    typedef struct packed {
        logic [9:0]        fu_code;
        logic [6:0]        uopc;
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] pdst;
        logic [BR_W-1:0]   br_mask;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
    } exe_req_t;

    function automatic logic br_killed(input logic [BR_W-1:0] mask, input logic [BR_W-1:0] mispredict);
        return |(mask & mispredict);
    endfunction

    function automatic logic [BR_W-1:0] br_update(input logic [BR_W-1:0] mask, input logic [BR_W-1:0] resolve);
        return mask & ~resolve;
    endfunction
endpackage

// File: rtl/exe_req_entry.sv
// exe_req_entry: one valid+payload slot; resolved branch bits are cleared on load and while held.
module exe_req_entry
    import exe_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            clr,
    input  exe_req_t        d,
    input  logic [BR_W-1:0] resolve,
    output logic            valid,
    output exe_req_t        q
);
    // Only valid and br_mask are reset; the operand payload is left unreset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid     <= 1'b0;
            q.br_mask <= '0;
        end else if (load) begin
            valid     <= 1'b1;
            q         <= d;
            q.br_mask <= br_update(d.br_mask, resolve);
        end else begin
            valid     <= valid & ~clr;
            q.br_mask <= br_update(q.br_mask, resolve);
        end
    end
endmodule

// File: rtl/exe_req_skid_stage.sv
// exe_req_skid_stage: registered request stage with a 2-entry skid buffer in front of the ALU.
// Optional EXE_REQ_PERF_EN adds saturating stall/kill counters.
module exe_req_skid_stage
    import exe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_fu_code,
    input  logic [6:0]        in_uopc,
    input  logic [ROB_W-1:0]  in_rob_idx,
    input  logic [PREG_W-1:0] in_pdst,
    input  logic [BR_W-1:0]   in_br_mask,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [BR_W-1:0]   brupdate_resolve_mask,
    input  logic [BR_W-1:0]   brupdate_mispredict_mask,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_fu_code,
    output logic [6:0]        out_uopc,
    output logic [ROB_W-1:0]  out_rob_idx,
    output logic [PREG_W-1:0] out_pdst,
    output logic [BR_W-1:0]   out_br_mask,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic              out_kill
`ifdef EXE_REQ_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_kills
`endif
);
    exe_req_t in_req, main_q, skid_q;
    logic main_valid, skid_valid, skid_alive, main_stays, accept, push;
    logic main_load, main_clr, skid_load, skid_clr;

    assign in_req = '{fu_code: in_fu_code, uopc: in_uopc, rob_idx: in_rob_idx, pdst: in_pdst,
                      br_mask: in_br_mask, rs1_data: in_rs1_data, rs2_data: in_rs2_data};

    assign in_ready   = ~skid_valid;
    assign out_kill   = main_valid & (flush | br_killed(main_q.br_mask, brupdate_mispredict_mask));
    assign out_valid  = main_valid & ~out_kill;
    assign skid_alive = skid_valid & ~flush & ~br_killed(skid_q.br_mask, brupdate_mispredict_mask);
    assign main_stays = out_valid & ~out_ready;
    assign accept     = in_valid & in_ready;
    assign push       = accept & ~flush & ~br_killed(in_br_mask, brupdate_mispredict_mask);

    // Survivors stay ordered: held main, then surviving skid, then the new request.
    // A push can never coincide with a live skid because in_ready is low then.
    assign main_load = ~main_stays & (skid_alive | push);
    assign main_clr  = ~main_stays & ~main_load;
    assign skid_load = main_stays & push;
    assign skid_clr  = ~(main_stays & skid_alive) & ~skid_load;

    exe_req_entry u_main (
        .clock(clock), .reset(reset), .load(main_load), .clr(main_clr),
        .d(skid_alive ? skid_q : in_req), .resolve(brupdate_resolve_mask),
        .valid(main_valid), .q(main_q)
    );

    exe_req_entry u_skid (
        .clock(clock), .reset(reset), .load(skid_load), .clr(skid_clr),
        .d(in_req), .resolve(brupdate_resolve_mask),
        .valid(skid_valid), .q(skid_q)
    );

    assign out_fu_code  = main_q.fu_code;
    assign out_uopc     = main_q.uopc;
    assign out_rob_idx  = main_q.rob_idx;
    assign out_pdst     = main_q.pdst;
    assign out_br_mask  = br_update(main_q.br_mask, brupdate_resolve_mask);
    assign out_rs1_data = main_q.rs1_data;
    assign out_rs2_data = main_q.rs2_data;

`ifdef EXE_REQ_PERF_EN
    logic [31:0] kills;
    assign kills = 32'(out_kill) + 32'(skid_valid & ~skid_alive) + 32'(accept & ~push);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_kills        <= '0;
        end else begin
            if (in_valid & ~in_ready & ~&perf_stall_cycles)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            perf_kills <= (perf_kills > ~kills) ? '1 : perf_kills + kills;
        end
    end
`endif
endmodule

// File: tb/tb_exe_req_skid_stage.sv
// tb_exe_req_skid_stage: directed self-checking bench for exe_req_skid_stage (default build).
module tb_exe_req_skid_stage;
    import exe_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [9:0]        in_fu_code;
    logic [6:0]        in_uopc;
    logic [ROB_W-1:0]  in_rob_idx;
    logic [PREG_W-1:0] in_pdst;
    logic [BR_W-1:0]   in_br_mask;
    logic [DATA_W-1:0] in_rs1_data, in_rs2_data;
    logic [BR_W-1:0]   resolve, mispredict;
    logic              flush;
    logic              out_valid, out_ready, out_kill;
    logic [9:0]        out_fu_code;
    logic [6:0]        out_uopc;
    logic [ROB_W-1:0]  out_rob_idx;
    logic [PREG_W-1:0] out_pdst;
    logic [BR_W-1:0]   out_br_mask;
    logic [DATA_W-1:0] out_rs1_data, out_rs2_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    exe_req_skid_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fu_code(in_fu_code), .in_uopc(in_uopc), .in_rob_idx(in_rob_idx), .in_pdst(in_pdst),
        .in_br_mask(in_br_mask), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .brupdate_resolve_mask(resolve), .brupdate_mispredict_mask(mispredict), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fu_code(out_fu_code), .out_uopc(out_uopc), .out_rob_idx(out_rob_idx), .out_pdst(out_pdst),
        .out_br_mask(out_br_mask), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_kill(out_kill)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_fu_code = '0; in_uopc = '0; in_rob_idx = '0; in_pdst = '0;
        in_br_mask = '0; in_rs1_data = '0; in_rs2_data = '0;
        resolve = '0; mispredict = '0; flush = 1'b0;
    endtask

    task automatic drive(input logic [ROB_W-1:0] rob, input logic [BR_W-1:0] mask);
        in_valid = 1'b1; in_rob_idx = rob; in_br_mask = mask;
        in_pdst = rob + 7'd1; in_uopc = 7'h2A; in_fu_code = 10'h001;
        in_rs1_data = {58'd0, rob}; in_rs2_data = {1'b1, 57'd0, rob};
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b0;
        reset = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_kill !== 1'b0) begin errors++; $display("FAIL reset_out_kill got=%b exp=0", out_kill); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_br_mask !== 20'h0) begin errors++; $display("FAIL reset_br_mask got=%h exp=0", out_br_mask); end
        #1 reset = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; in_rob_idx = 7'h15; in_pdst = 7'h33; in_uopc = 7'h11; in_fu_code = 10'h204;
        in_br_mask = '0; in_rs1_data = 65'h1_0000_0000_0000_0005; in_rs2_data = 65'h0_DEAD_BEEF_0000_1234;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready_pre got=%b exp=1", in_ready); end
        tick();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_rob_idx !== 7'h15) begin errors++; $display("FAIL single_rob got=%h exp=15", out_rob_idx); end
        checks++; if (out_rs1_data !== 65'h1_0000_0000_0000_0005) begin errors++; $display("FAIL single_rs1 got=%h exp=10000000000000005", out_rs1_data); end
        checks++; if (out_rs2_data !== 65'h0_DEAD_BEEF_0000_1234) begin errors++; $display("FAIL single_rs2 got=%h exp=deadbeef00001234", out_rs2_data); end
        checks++; if (out_pdst !== 7'h33 || out_uopc !== 7'h11 || out_fu_code !== 10'h204) begin errors++; $display("FAIL single_fields got=%h/%h/%h exp=33/11/204", out_pdst, out_uopc, out_fu_code); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(7'd1, '0);
        tick();
        drive(7'd2, '0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one got=%b exp=1", in_ready); end
        tick();
        drive(7'd3, '0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_rob_idx !== 7'd1) begin errors++; $display("FAIL b2b_head0 got=%b/%0d exp=1/1", out_valid, out_rob_idx); end
        tick();
        checks++; if (out_rob_idx !== 7'd1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got=%0d/%b exp=1/0", out_rob_idx, in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_pop got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rob_idx !== 7'd2) begin errors++; $display("FAIL b2b_head1 got=%b/%0d exp=1/2", out_valid, out_rob_idx); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise got=%b exp=1", in_ready); end
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || out_rob_idx !== 7'd3) begin errors++; $display("FAIL b2b_head2 got=%b/%0d exp=1/3", out_valid, out_rob_idx); end
        checks++; if (out_rs1_data !== 65'd3) begin errors++; $display("FAIL b2b_rs1 got=%h exp=3", out_rs1_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_br_update();
        out_ready = 1'b0;
        drive(7'd9, 20'h00003);
        tick();
        idle();
        checks++; if (out_br_mask !== 20'h00003) begin errors++; $display("FAIL br_held got=%h exp=00003", out_br_mask); end
        resolve = 20'h00001;
        #1;
        checks++; if (out_br_mask !== 20'h00002) begin errors++; $display("FAIL br_resolve_comb got=%h exp=00002", out_br_mask); end
        tick();
        resolve = '0;
        #1;
        checks++; if (out_br_mask !== 20'h00002 || out_valid !== 1'b1) begin errors++; $display("FAIL br_resolved got=%h/%b exp=00002/1", out_br_mask, out_valid); end
        mispredict = 20'h00002;
        #1;
        checks++; if (out_kill !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL br_kill got=%b/%b exp=1/0", out_kill, out_valid); end
        tick();
        mispredict = '0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_kill !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL br_gone got=%b/%b/%b exp=0/0/1", out_valid, out_kill, in_ready); end
    endtask

    task automatic test_kill_promote();
        out_ready = 1'b0;
        drive(7'd4, 20'h00001);
        tick();
        drive(7'd5, 20'h00010);
        tick();
        idle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL kp_full got=%b exp=0", in_ready); end
        mispredict = 20'h00001;
        #1;
        checks++; if (out_kill !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL kp_kill got=%b/%b exp=1/0", out_kill, out_valid); end
        tick();
        mispredict = '0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_rob_idx !== 7'd5 || out_br_mask !== 20'h00010) begin errors++; $display("FAIL kp_promote got=%b/%0d/%h exp=1/5/00010", out_valid, out_rob_idx, out_br_mask); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kp_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(7'd6, '0);
        tick();
        drive(7'd7, '0);
        tick();
        drive(7'd8, '0);
        flush = 1'b1;
        #1;
        checks++; if (out_kill !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got=%b/%b exp=1/0", out_kill, out_valid); end
        tick();
        idle();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b/%b exp=0/1", out_valid, in_ready); end
        drive(7'd10, '0);
        flush = 1'b1;
        tick();
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_incoming got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_stable got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(7'd11, '0);
        tick();
        drive(7'd12, '0);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_full got=%b/%b exp=1/0", out_valid, in_ready); end
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_immediate got=%b exp=0", out_valid); end
        #1 reset = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_release got=%b/%b exp=0/1", out_valid, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_no_stale got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_br_update();
        test_kill_promote();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
